// File: rtl/fetch_unit.sv
// Program-counter and instruction-fetch front end.
// Holds the PC, issues word-addressed fetches over a req/ack handshake,
// presents the fetched instruction to decode and loads the next PC on advance.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        inst_accept,
  input  logic        stall,
  input  logic [31:0] next_inst,
  output logic        fetch_err
);

  typedef enum logic [1:0] {IDLE, FETCH, VALID, ERROR} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt, wait_cnt_nxt;
  logic [31:0] pc_nxt, inst_nxt;
  logic        fetch_err_nxt;

  // State and datapath registers, all cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      pc        <= RESET_PC;
      inst      <= '0;
      fetch_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      pc        <= pc_nxt;
      inst      <= inst_nxt;
      fetch_err <= fetch_err_nxt;
    end
  end

  // Next-state, handshake and PC/instruction update decisions.
  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    pc_nxt        = pc;
    inst_nxt      = inst;
    fetch_err_nxt = fetch_err;
    case (state)
      IDLE: begin
        state_nxt    = FETCH;
        wait_cnt_nxt = '0;
      end
      FETCH: begin
        if (imem_ack) begin
          inst_nxt  = imem_rdata;
          state_nxt = VALID;
        end else if (wait_cnt == WAIT_LAST) begin
          fetch_err_nxt = 1'b1;
          state_nxt     = ERROR;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      VALID: begin
        if (inst_accept && !stall) begin
          pc_nxt       = next_inst;
          wait_cnt_nxt = '0;
          state_nxt    = FETCH;
        end
      end
      ERROR: begin
        state_nxt = ERROR;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state and pc only.
  always_comb begin
    imem_req   = (state == FETCH);
    inst_valid = (state == VALID);
    imem_addr  = pc;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// instruction stream checked against a transaction-level model (expected
// fetch address sequence and a fixed memory content function).
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'd0;
  localparam int unsigned TIMEOUT  = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_accept;
  logic        stall;
  logic [31:0] next_inst;
  logic        fetch_err;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] exp_pc;

  fetch_unit #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc(pc), .inst(inst),
    .inst_valid(inst_valid), .inst_accept(inst_accept), .stall(stall),
    .next_inst(next_inst), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  // Memory content as a fixed function of the word address.
  function automatic logic [31:0] mem_data(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
    inst_accept = 1'b0; stall = 1'b0; next_inst = '0;
    tick; tick;
    reset = 1'b0;
    exp_pc = RESET_PC;
  endtask

  // Entry: unit is fetching exp_pc. Memory acks after `delay` wait cycles.
  task automatic do_fetch(input int unsigned delay);
    for (int unsigned i = 0; i < delay; i++) begin
      check("fetch_req", 32'(imem_req), 32'd1);
      check("fetch_addr", imem_addr, exp_pc);
      check("fetch_noval", 32'(inst_valid), 32'd0);
      imem_rdata = $urandom;
      tick;
    end
    check("fetch_req", 32'(imem_req), 32'd1);
    check("fetch_addr", imem_addr, exp_pc);
    imem_ack = 1'b1;
    imem_rdata = mem_data(exp_pc);
    tick;
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    check("got_valid", 32'(inst_valid), 32'd1);
    check("got_inst", inst, mem_data(exp_pc));
    check("got_pc", pc, exp_pc);
    check("got_req_low", 32'(imem_req), 32'd0);
  endtask

  // Entry: instruction valid. Advance with the given next PC.
  task automatic do_advance(input logic [31:0] nxt);
    inst_accept = 1'b1; stall = 1'b0; next_inst = nxt;
    tick;
    inst_accept = 1'b0; next_inst = $urandom;
    exp_pc = nxt;
    check("adv_noval", 32'(inst_valid), 32'd0);
    check("adv_req", 32'(imem_req), 32'd1);
    check("adv_addr", imem_addr, nxt);
    check("adv_err", 32'(fetch_err), 32'd0);
  endtask

  // Entry: instruction valid. Random non-advancing cycles with ack noise.
  task automatic valid_hold(input int unsigned cycles);
    for (int unsigned i = 0; i < cycles; i++) begin
      stall = 1'($urandom);
      inst_accept = stall ? 1'($urandom) : 1'b0;
      next_inst = $urandom;
      imem_ack = 1'($urandom);
      imem_rdata = $urandom;
      tick;
      check("hold_valid", 32'(inst_valid), 32'd1);
      check("hold_inst", inst, mem_data(exp_pc));
      check("hold_pc", pc, exp_pc);
      check("hold_req", 32'(imem_req), 32'd0);
    end
    imem_ack = 1'b0; stall = 1'b0; inst_accept = 1'b0;
  endtask

  initial begin
    int unsigned req_cycles;
    logic [31:0] nxt;

    // Reset state
    do_reset;
    reset = 1'b1;
    #1;
    check("rst_pc", pc, RESET_PC);
    check("rst_inst", inst, 32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_err", 32'(fetch_err), 32'd0);

    // Release with ack tied high: req one cycle later, valid the cycle after
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    reset = 1'b0;
    check("idle_req", 32'(imem_req), 32'd0);
    tick;
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, RESET_PC);
    tick;
    imem_ack = 1'b0;
    check("first_valid", 32'(inst_valid), 32'd1);
    check("first_inst", inst, 32'h1234_5678);

    // Sequential flow, memory acks 2 cycles after req
    do_reset;
    tick;
    for (int unsigned a = 0; a < 4; a++) begin
      do_fetch(2);
      if (a < 3) do_advance(exp_pc + 32'd1);
    end
    check("seq_pc", pc, 32'd3);

    // Stall for 5 cycles with accept high, then jump to 0x40
    inst_accept = 1'b1; stall = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      next_inst = $urandom;
      tick;
      check("stall_valid", 32'(inst_valid), 32'd1);
      check("stall_pc", pc, 32'd3);
      check("stall_inst", inst, mem_data(32'd3));
    end
    do_advance(32'h40);
    do_fetch(0);

    // Wrap-around
    do_advance(32'hFFFF_FFFF);
    do_fetch(1);
    do_advance(32'h0);
    do_fetch(0);
    check("wrap_err", 32'(fetch_err), 32'd0);

    // Randomized stream
    for (int unsigned n = 0; n < 60; n++) begin
      valid_hold($urandom_range(0, 3));
      nxt = ($urandom_range(0, 3) == 0) ? 32'($urandom) : exp_pc + 32'd1;
      do_advance(nxt);
      do_fetch($urandom_range(0, 4));
    end

    // Timeout: no ack ever
    do_reset;
    tick;
    req_cycles = 0;
    for (int unsigned i = 0; i < TIMEOUT + 4 && fetch_err == 1'b0; i++) begin
      if (imem_req) req_cycles++;
      tick;
    end
    check("tmo_cycles", req_cycles, TIMEOUT);
    check("tmo_err", 32'(fetch_err), 32'd1);
    for (int unsigned i = 0; i < 10; i++) begin
      imem_ack = 1'($urandom); imem_rdata = $urandom;
      inst_accept = 1'($urandom); next_inst = $urandom;
      tick;
      check("err_req", 32'(imem_req), 32'd0);
      check("err_valid", 32'(inst_valid), 32'd0);
      check("err_sticky", 32'(fetch_err), 32'd1);
      check("err_pc", pc, RESET_PC);
    end
    do_reset;
    check("err_clear", 32'(fetch_err), 32'd0);
    tick;
    check("err_restart", imem_addr, RESET_PC);
    do_fetch(1);

    // Reset mid-fetch, late ack after release
    do_advance(32'h0000_0077);
    check("mid_req", 32'(imem_req), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_req_drop", 32'(imem_req), 32'd0);
    tick;
    reset = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick;
    imem_ack = 1'b0;
    check("late_noval", 32'(inst_valid), 32'd0);
    check("late_req", 32'(imem_req), 32'd1);
    check("late_addr", imem_addr, RESET_PC);
    exp_pc = RESET_PC;
    do_fetch(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Program-counter and instruction-fetch front end. It consumes the next-instruction address produced by the next-PC/branch logic and supplies that logic with `pc` and the fetched instruction. It holds the PC register and issues word-addressed fetches to instruction memory over a req/ack handshake. It presents each fetched instruction to decode until decode accepts it, then loads the next PC.

Parameters:
- RESET_PC, 32'd0, PC value loaded on reset (word address).
- TIMEOUT, 16, cycles without imem_ack before fetch_err is raised; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  word address of the fetch; equals pc.
- imem_ack  in  1  memory has returned imem_rdata this cycle.
- imem_rdata  in  32  instruction word, valid only with imem_ack.
- pc  out  32  current PC; drives the next-PC logic address input.
- inst  out  32  latched instruction. inst[25:0] feeds the jump field; inst[15:0] feeds the sign extender.
- inst_valid  out  1  inst holds a fetched, unconsumed instruction.
- inst_accept  in  1  decode/execute consumes inst this cycle.
- stall  in  1  hazard stall; blocks PC update.
- next_inst  in  32  next PC from next-PC logic; sampled on advance.
- fetch_err  out  1  sticky: memory failed to ack within TIMEOUT cycles.

Behaviour:
- All state registers are cleared asynchronously when reset=1.
- Reset values:
  - pc=RESET_PC
  - inst=32'd0
  - inst_valid=0
  - imem_req=0
  - fetch_err=0
  - state=IDLE
  - wait counter=0
- States: IDLE, FETCH, VALID, ERROR.
- IDLE: imem_req=0. Moves to FETCH unconditionally on the first clock edge after reset deasserts.
- FETCH:
  - imem_req=1 and imem_addr=pc, held stable until ack.
  - On imem_ack=1: inst<=imem_rdata, inst_valid<=1, move to VALID. imem_req is low from the next cycle.
  - Otherwise the wait counter increments. When the counter reaches TIMEOUT-1 without ack: fetch_err<=1, move to ERROR.
  - The wait counter clears on every entry to FETCH.
- VALID:
  - inst_valid=1, imem_req=0.
  - Advance condition: inst_accept=1 and stall=0. On advance: pc<=next_inst, inst_valid<=0, move to FETCH.
  - If stall=1, pc, inst and inst_valid hold regardless of inst_accept.
  - If inst_accept=0, everything holds.
- ERROR: imem_req=0 and inst_valid=0. pc and fetch_err hold. Exit is by reset only.
- imem_req, inst_valid and imem_addr are decoded from registered state and pc only. There is no combinational path from any input to any output.
- imem_ack is ignored when imem_req=0 (IDLE, VALID, ERROR).
- The earliest ack is in the first FETCH cycle. Minimum throughput is one instruction per 2 cycles (FETCH, VALID).
- next_inst is loaded verbatim; no arithmetic on pc inside this block.
  - Wrap-around (pc=32'hFFFFFFFF, next_inst=0) is legal and fetches address 0.
  - Word addressing: the next-PC logic adds 1, not 4.
- If reset asserts mid-fetch, the outstanding request is abandoned and imem_req drops immediately (asynchronous). A late ack after reset release is ignored in IDLE.
- The pc output always shows the PC of the instruction currently in inst while inst_valid=1. This keeps next_inst consistent for branch/jump computation.

Test Plan:
- Reset release with RESET_PC=0 and imem_ack tied high → imem_req rises 1 cycle after reset release with imem_addr=0. inst_valid=1 the following cycle with inst=imem_rdata.
- Sequential flow: memory acks 2 cycles after req; inst_accept held high; next_inst=pc+1 → fetch addresses 0,1,2,3 in order, each inst_valid pulse matches that address's data, and imem_addr never changes while imem_req=1.
- Stall: stall=1 for 5 cycles in VALID with inst_accept=1 → pc, inst and inst_valid unchanged for all 5 cycles. The advance happens on the first cycle with stall=0, and pc takes that cycle's next_inst (e.g. 32'h40 for a jump).
- Wrap: pc=32'hFFFFFFFF, next_inst=0 on advance → next imem_addr=0; no error.
- Timeout with TIMEOUT=16: imem_ack never asserted → fetch_err=1 after 16 FETCH cycles, imem_req=0 thereafter, and ERROR state persists until reset. A subsequent reset clears fetch_err and restarts from RESET_PC.
- Reset mid-fetch: assert reset while imem_req=1, then send an ack 1 cycle after release → imem_req low immediately, the ack is ignored (inst_valid stays 0), and the fetch restarts at RESET_PC.
